// File: rtl/rename_register_file_if.sv
// rename_register_file_if: dispatcher/ROB bus for the rename register file.
//   master: dispatcher + ROB side (drives indices, rename and commit requests, rollback)
//   slave : register file side (drives operand values and producer tags)
interface rename_register_file_if #(
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4
);
    logic [REG_W-1:0]  rs1_from_dispatcher;
    logic [REG_W-1:0]  rs2_from_dispatcher;
    logic [DATA_W-1:0] V1_to_dispatcher;
    logic [ROB_W-1:0]  Q1_to_dispatcher;
    logic [DATA_W-1:0] V2_to_dispatcher;
    logic [ROB_W-1:0]  Q2_to_dispatcher;
    logic              enable_from_dispatcher;
    logic [REG_W-1:0]  rd_from_dispatcher;
    logic [ROB_W-1:0]  rob_id_from_dispatcher;
    logic              commit_flag;
    logic [REG_W-1:0]  rd_from_rob;
    logic [DATA_W-1:0] V_from_rob;
    logic [ROB_W-1:0]  Q_from_rob;
    logic              rollback_flag;
    modport master (
        output rs1_from_dispatcher, rs2_from_dispatcher, enable_from_dispatcher,
               rd_from_dispatcher, rob_id_from_dispatcher, commit_flag, rd_from_rob,
               V_from_rob, Q_from_rob, rollback_flag,
        input  V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher
    );
    modport slave (
        input  rs1_from_dispatcher, rs2_from_dispatcher, enable_from_dispatcher,
               rd_from_dispatcher, rob_id_from_dispatcher, commit_flag, rd_from_rob,
               V_from_rob, Q_from_rob, rollback_flag,
        output V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher
    );
endinterface

// File: rtl/rename_register_file.sv
// rename_register_file: architectural registers with per-register rename tags (ROB producer ids).
//   clk_in : clock
//   rst_in : synchronous active-high reset, clears all values and tags
//   rdy_in : global ready, state holds when low
//   bus    : slave side of the dispatcher/ROB bus (reads, rename, commit, rollback)
module rename_register_file #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input logic                   clk_in,
    input logic                   rst_in,
    input logic                   rdy_in,
    rename_register_file_if.slave bus
);
    logic [DATA_W-1:0] value [REG_NUM];
    logic [ROB_W-1:0]  tag   [REG_NUM];
    logic              byp1, byp2, commit_ok;
    // A commit forwards to a read only if it is the newest producer of that register.
    assign commit_ok = bus.commit_flag && bus.rd_from_rob != '0;
    always_comb begin
        byp1 = commit_ok && bus.rd_from_rob == bus.rs1_from_dispatcher
               && tag[bus.rs1_from_dispatcher] == bus.Q_from_rob;
        byp2 = commit_ok && bus.rd_from_rob == bus.rs2_from_dispatcher
               && tag[bus.rs2_from_dispatcher] == bus.Q_from_rob;
        bus.V1_to_dispatcher = bus.rs1_from_dispatcher == '0 ? '0 :
                               byp1 ? bus.V_from_rob : value[bus.rs1_from_dispatcher];
        bus.Q1_to_dispatcher = (bus.rs1_from_dispatcher == '0 || byp1) ? '0 : tag[bus.rs1_from_dispatcher];
        bus.V2_to_dispatcher = bus.rs2_from_dispatcher == '0 ? '0 :
                               byp2 ? bus.V_from_rob : value[bus.rs2_from_dispatcher];
        bus.Q2_to_dispatcher = (bus.rs2_from_dispatcher == '0 || byp2) ? '0 : tag[bus.rs2_from_dispatcher];
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_ok)
                value[bus.rd_from_rob] <= bus.V_from_rob;
            if (bus.rollback_flag) begin
                for (int i = 0; i < REG_NUM; i++)
                    tag[i] <= '0;
            end else begin
                // Stale commits (tag re-renamed since) leave the tag alone; rename is last so it wins.
                if (commit_ok && tag[bus.rd_from_rob] == bus.Q_from_rob)
                    tag[bus.rd_from_rob] <= '0;
                if (bus.enable_from_dispatcher && bus.rd_from_dispatcher != '0)
                    tag[bus.rd_from_dispatcher] <= bus.rob_id_from_dispatcher;
            end
        end
    end
endmodule
